// File: rtl/puzzle_game_ctrl.sv
// Switch-puzzle game sequencer: start -> load testcase -> capture presses
// against a per-testcase budget -> compare with answer -> hold win/lose.
module puzzle_game_ctrl #(
  parameter int unsigned RESULT_CYCLES = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       testcase,
  input  logic [9:0]       switch,
  input  logic [9:0]       answer,
  output logic             play_en,
  output logic [9:0]       my_sol,
  output logic [CNT_W-1:0] press_cnt,
  output logic [2:0]       state,
  output logic             is_finish,
  output logic             success
);

  localparam int unsigned TMR_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_CHECK = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       tc_q, tc_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       sol_q, sol_d;
  logic [9:0]       switch_q, switch_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [9:0]       rise;
  logic             budget_hit;

  function automatic logic [CNT_W-1:0] budget_of(input logic [1:0] tc);
    case (tc)
      2'd3:    budget_of = CNT_W'(3);
      2'd2:    budget_of = CNT_W'(4);
      2'd1:    budget_of = CNT_W'(6);
      default: budget_of = '0;
    endcase
  endfunction

  assign rise       = switch & ~switch_q;
  assign budget_hit = (cnt_q == budget_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tc_q     <= '0;
      budget_q <= '0;
      cnt_q    <= '0;
      sol_q    <= '0;
      switch_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      tc_q     <= tc_d;
      budget_q <= budget_d;
      cnt_q    <= cnt_d;
      sol_q    <= sol_d;
      switch_q <= switch_d;
      timer_q  <= timer_d;
    end
  end

  // Next-state selection; abort outranks budget-reached and the CHECK decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (testcase != 2'd0)) state_d = S_LOAD;
      S_LOAD:  state_d = abort ? S_IDLE : S_PLAY;
      S_PLAY: begin
        if (abort)           state_d = S_IDLE;
        else if (budget_hit) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (abort)                 state_d = S_IDLE;
        else if (sol_q == answer)  state_d = S_WIN;
        else                       state_d = S_LOSE;
      end
      S_WIN, S_LOSE: if (timer_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: testcase latch, budget, press capture and result timer
  always_comb begin
    tc_d     = tc_q;
    budget_d = budget_q;
    cnt_d    = cnt_q;
    sol_d    = sol_q;
    switch_d = switch;
    timer_d  = timer_q;
    case (state_q)
      S_IDLE: if (start && (testcase != 2'd0)) tc_d = testcase;
      S_LOAD: begin
        sol_d    = '0;
        cnt_d    = '0;
        budget_d = budget_of(tc_q);
      end
      S_PLAY: begin
        if (abort) begin
          sol_d = '0;
          cnt_d = '0;
        end else if (!budget_hit && (rise != '0)) begin
          sol_d = sol_q | rise;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (abort) begin
          sol_d = '0;
          cnt_d = '0;
        end else begin
          timer_d = TMR_W'(RESULT_CYCLES - 1);
        end
      end
      S_WIN, S_LOSE: if (timer_q != '0) timer_d = timer_q - TMR_W'(1);
      default: ;
    endcase
  end

  // Outputs decoded purely from registered state
  always_comb begin
    play_en   = (state_q == S_PLAY);
    is_finish = (state_q == S_WIN) || (state_q == S_LOSE);
    success   = (state_q == S_WIN);
    state     = state_q;
    my_sol    = sol_q;
    press_cnt = cnt_q;
  end

endmodule

// File: tb/tb_puzzle_game_ctrl.sv
// Randomized scoreboard bench for puzzle_game_ctrl.
module tb_puzzle_game_ctrl;

  localparam int unsigned RC = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [1:0]    testcase;
  logic [9:0]    switch, answer;
  logic          play_en, is_finish, success;
  logic [9:0]    my_sol;
  logic [CW-1:0] press_cnt;
  logic [2:0]    state;

  puzzle_game_ctrl #(.RESULT_CYCLES(RC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .testcase(testcase), .switch(switch), .answer(answer),
    .play_en(play_en), .my_sol(my_sol), .press_cnt(press_cnt),
    .state(state), .is_finish(is_finish), .success(success)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          win;
    logic [9:0]    sol;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] vecs[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int budget_for(input logic [1:0] tc);
    case (tc)
      2'd3: return 3;
      2'd2: return 4;
      2'd1: return 6;
      default: return 0;
    endcase
  endfunction

  // Reference: vecs[0] is the switch level during LOAD, vecs[i] the level on
  // the i-th PLAY cycle. A press is any cycle with a new rising bit, until the
  // budget is used up; done means the budget-reached cycle is covered.
  function automatic void model(input logic [1:0] tc, output int cnt,
                                output logic [9:0] sol, output bit done);
    int b = budget_for(tc);
    logic [9:0] r;
    cnt = 0; sol = '0; done = 0;
    for (int i = 1; i < vecs.size(); i++) begin
      if (cnt == b) begin done = 1; break; end
      r = vecs[i] & ~vecs[i-1];
      if (r != '0) begin
        sol = sol | r;
        cnt++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_game(input logic [1:0] tc, input logic [9:0] ans, input logic [9:0] pre);
    int c; logic [9:0] s; bit d; exp_t e;
    model(tc, c, s, d);
    e.win = (s == ans); e.sol = s; e.cnt = CW'(c);
    sb.push_back(e);
    answer = ans; switch = pre;
    tick();
    start = 1'b1; testcase = tc;
    tick();
    start = 1'b0;
    chk("enter_load", state, 1);
    testcase = 2'($urandom);
    foreach (vecs[i]) begin
      switch = vecs[i];
      tick();
    end
    for (int n = 0; n < 100 && state != 3'd0; n++) tick();
    chk("game_done", state, 0);
  endtask

  // Monitor: pops an expectation whenever a result is presented
  logic fin_prev = 1'b0;
  int   dur = 0;
  bit   have = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (is_finish && !fin_prev) begin
      dur = 1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow actual=result expected=none");
        have = 0;
      end else begin
        cur = sb.pop_front();
        have = 1;
        chk("result_success", success, cur.win);
        chk("result_sol", my_sol, cur.sol);
        chk("result_cnt", press_cnt, cur.cnt);
      end
    end else if (is_finish) begin
      dur++;
      if (have) chk("hold_success", success, cur.win);
    end else if (fin_prev && have) begin
      chk("hold_len", dur, RC);
      chk("idle_after", state, 0);
      chk("sol_retained", my_sol, cur.sol);
      have = 0;
    end
    fin_prev = is_finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int c; logic [9:0] s; bit d; logic [1:0] tc; logic [9:0] v;
    reset = 1'b1; start = 1'b0; abort = 1'b0; testcase = '0;
    switch = '0; answer = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_state", state, 0);
    chk("rst_sol", my_sol, 0);
    chk("rst_cnt", press_cnt, 0);
    chk("rst_finish", is_finish, 0);
    chk("rst_play", play_en, 0);

    start = 1'b1; testcase = 2'd0;
    tick();
    start = 1'b0;
    chk("tc0_ignored", state, 0);

    // Win with three single-bit presses
    vecs = '{10'h000, 10'h001, 10'h003, 10'h007};
    run_game(2'd3, 10'h007, 10'h000);
    // Repeat press on bit 0 still counts; lose
    vecs = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h006, 10'h007};
    run_game(2'd2, 10'h00F, 10'h000);
    // Rise coinciding with the budget-reached cycle is ignored
    vecs = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h03F};
    run_game(2'd3, 10'h03F, 10'h000);

    // Abort during LOAD clears the visible result
    start = 1'b1; testcase = 2'd3;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_load_state", state, 0);
    chk("abort_load_sol", my_sol, 0);

    // Bit held through start is not a press; two bits rising together = one press
    switch = 10'h020;
    tick();
    start = 1'b1; testcase = 2'd1;
    tick();
    start = 1'b0;
    tick();
    switch = 10'h038;
    tick();
    chk("multi_cnt", press_cnt, 1);
    chk("multi_sol", my_sol, 10'h018);
    chk("multi_play", play_en, 1);
    switch = 10'h039;
    tick();
    chk("second_cnt", press_cnt, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", state, 0);
    chk("abort_sol", my_sol, 0);
    chk("abort_cnt", press_cnt, 0);

    // Reset mid-game
    switch = 10'h000;
    tick();
    start = 1'b1; testcase = 2'd2;
    tick();
    start = 1'b0;
    tick();
    switch = 10'h001; tick();
    switch = 10'h003; tick();
    chk("pre_reset_cnt", press_cnt, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_state", state, 0);
    chk("reset_sol", my_sol, 0);
    chk("reset_cnt", press_cnt, 0);
    chk("reset_finish", is_finish, 0);

    // Randomized games
    for (int g = 0; g < 25; g++) begin
      tc = 2'($urandom_range(1, 3));
      vecs = {};
      vecs.push_back(10'($urandom));
      d = 0;
      for (int k = 0; k < 80 && !d; k++) begin
        v = ($urandom_range(0, 3) == 0) ? vecs[vecs.size()-1] : 10'($urandom);
        vecs.push_back(v);
        model(tc, c, s, d);
      end
      model(tc, c, s, d);
      run_game(tc, ($urandom_range(0, 1) == 1) ? s : 10'($urandom), 10'($urandom));
    end

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
